// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store
// path (c_*) and a debug/DMA master (d_*). Round-robin grant, one access in
// flight, variable memory latency with a timeout that aborts a stuck access
// with an error response instead of stalling the requester forever.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Owner / last-grant encoding: 0 = core, 1 = debug
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;
    // Last counter value before the access is abandoned
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state_r, state_s;
    logic               owner_r, owner_s;
    logic               last_grant_r, last_grant_s;
    logic [7:0]         cnt_r, cnt_s;
    logic               m_req_r, m_req_s;
    logic               m_we_r, m_we_s;
    logic [ADDR_W-1:0]  m_addr_r, m_addr_s;
    logic [DATA_W-1:0]  m_wdata_r, m_wdata_s;
    logic               c_done_r, c_done_s;
    logic               d_done_r, d_done_s;
    logic               c_err_r, c_err_s;
    logic               d_err_r, d_err_s;
    logic [DATA_W-1:0]  c_rdata_r, c_rdata_s;
    logic [DATA_W-1:0]  d_rdata_r, d_rdata_s;
    logic               busy_r;
    logic               pick_s;
    logic               fin_s;
    logic               fin_err_s;
    logic [DATA_W-1:0]  fin_data_s;

    // Next-state and next-output computation for every registered signal
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        m_req_s      = 1'b0;
        m_we_s       = m_we_r;
        m_addr_s     = m_addr_r;
        m_wdata_s    = m_wdata_r;
        c_done_s     = 1'b0;
        d_done_s     = 1'b0;
        c_err_s      = c_err_r;
        d_err_s      = d_err_r;
        c_rdata_s    = c_rdata_r;
        d_rdata_s    = d_rdata_r;
        pick_s       = OWN_CORE;
        fin_s        = 1'b0;
        fin_err_s    = 1'b0;
        fin_data_s   = {DATA_W{1'b0}};

        case (state_r)
            IDLE: begin
                // Tie goes to whoever was not served last
                if (c_req && d_req) begin
                    pick_s = (last_grant_r == OWN_CORE) ? OWN_DBG : OWN_CORE;
                end else if (d_req) begin
                    pick_s = OWN_DBG;
                end else begin
                    pick_s = OWN_CORE;
                end
                if (c_req || d_req) begin
                    owner_s      = pick_s;
                    last_grant_s = pick_s;
                    cnt_s        = 8'd0;
                    m_req_s      = 1'b1;
                    m_we_s       = (pick_s == OWN_DBG) ? d_we    : c_we;
                    m_addr_s     = (pick_s == OWN_DBG) ? d_addr  : c_addr;
                    m_wdata_s    = (pick_s == OWN_DBG) ? d_wdata : c_wdata;
                    state_s      = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // m_ready has priority over the timeout in the same cycle
                if (m_ready) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b0;
                    fin_data_s = m_rdata;
                end else if (cnt_r == CNT_LAST) begin
                    fin_s      = 1'b1;
                    fin_err_s  = 1'b1;
                    fin_data_s = {DATA_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                    m_req_s = 1'b1;
                end
                if (fin_s) begin
                    state_s = DONE;
                    if (owner_r == OWN_DBG) begin
                        d_done_s = 1'b1;
                        d_err_s  = fin_err_s;
                        // Stores leave the owner's read data untouched
                        if (fin_err_s || !m_we_r) begin
                            d_rdata_s = fin_data_s;
                        end else begin
                            d_rdata_s = d_rdata_r;
                        end
                    end else begin
                        c_done_s = 1'b1;
                        c_err_s  = fin_err_s;
                        if (fin_err_s || !m_we_r) begin
                            c_rdata_s = fin_data_s;
                        end else begin
                            c_rdata_s = c_rdata_r;
                        end
                    end
                end else begin
                    state_s = ACCESS;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CORE;
            last_grant_r <= OWN_DBG;
            cnt_r        <= 8'd0;
            m_req_r      <= 1'b0;
            m_we_r       <= 1'b0;
            m_addr_r     <= {ADDR_W{1'b0}};
            m_wdata_r    <= {DATA_W{1'b0}};
            c_done_r     <= 1'b0;
            d_done_r     <= 1'b0;
            c_err_r      <= 1'b0;
            d_err_r      <= 1'b0;
            c_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            m_req_r      <= m_req_s;
            m_we_r       <= m_we_s;
            m_addr_r     <= m_addr_s;
            m_wdata_r    <= m_wdata_s;
            c_done_r     <= c_done_s;
            d_done_r     <= d_done_s;
            c_err_r      <= c_err_s;
            d_err_r      <= d_err_s;
            c_rdata_r    <= c_rdata_s;
            d_rdata_r    <= d_rdata_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    assign m_req   = m_req_r;
    assign m_we    = m_we_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign c_done  = c_done_r;
    assign d_done  = d_done_r;
    assign c_err   = c_err_r;
    assign d_err   = d_err_r;
    assign c_rdata = c_rdata_r;
    assign d_rdata = d_rdata_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_done, c_err;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          d_req, d_we, d_done, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_ready, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state
    bit            last_d;      // 1: debug was granted last
    bit            win_last;    // winner of the most recent transaction
    logic [DW-1:0] exp_c_rdata, exp_d_rdata;
    int            last_done_cyc;
    int            gap;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic we, input logic [31:0] a, input logic [31:0] w);
        c_req = 1'b1; c_we = we; c_addr = a; c_wdata = w;
    endtask

    task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] w);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
    endtask

    // Starts at a negedge in IDLE with requests presented; ends at the
    // negedge of the following IDLE cycle. lat = wait cycles before m_ready.
    task automatic do_txn(input int lat, input bit keep, input bit scramble,
                          input logic [31:0] rdv);
        bit            win, tmo;
        logic          we_e;
        logic [31:0]   a_e, w_e, rd;
        int            n;
        if (c_req && d_req) win = !last_d;
        else win = d_req;
        last_d   = win;
        win_last = win;
        we_e = win ? d_we    : c_we;
        a_e  = win ? d_addr  : c_addr;
        w_e  = win ? d_wdata : c_wdata;
        tmo  = (lat > TO - 1);
        n    = tmo ? TO : lat + 1;
        rd   = 32'd0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk1("acc_m_req", m_req, 1'b1);
            chk1("acc_m_we", m_we, we_e);
            chk32("acc_m_addr", m_addr, a_e);
            chk32("acc_m_wdata", m_wdata, w_e);
            chk1("acc_busy", busy, 1'b1);
            chk1("acc_no_done", c_done | d_done, 1'b0);
            if (scramble && k == 0) begin
                if (win) begin d_addr = ~d_addr; d_wdata = ~d_wdata; d_we = ~d_we; end
                else begin c_addr = ~c_addr; c_wdata = ~c_wdata; c_we = ~c_we; end
            end
            rd      = (rdv != 32'd0) ? rdv : $urandom;
            m_rdata = rd;
            m_ready = (k == lat);
        end
        @(negedge clk);
        m_ready = $urandom_range(0, 1);   // ignored outside ACCESS
        m_rdata = $urandom;
        if (win) begin
            if (tmo) exp_d_rdata = 32'd0;
            else if (!we_e) exp_d_rdata = rd;
        end else begin
            if (tmo) exp_c_rdata = 32'd0;
            else if (!we_e) exp_c_rdata = rd;
        end
        chk1("done_c", c_done, !win);
        chk1("done_d", d_done, win);
        chk1("done_err", win ? d_err : c_err, tmo);
        chk32("c_rdata", c_rdata, exp_c_rdata);
        chk32("d_rdata", d_rdata, exp_d_rdata);
        chk1("done_m_req", m_req, 1'b0);
        chk1("done_busy", busy, 1'b1);
        gap = cyc - last_done_cyc;
        last_done_cyc = cyc;
        if (keep) begin
            if (win) set_d(1'($urandom), $urandom, $urandom);
            else     set_c(1'($urandom), $urandom, $urandom);
        end else begin
            if (win) d_req = 1'b0;
            else     c_req = 1'b0;
        end
        @(negedge clk);
        m_ready = 1'b0;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_no_done", c_done | d_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
        last_d = 1'b1; win_last = 1'b0;
        exp_c_rdata = '0; exp_d_rdata = '0;
        last_done_cyc = 0; gap = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", c_done | d_done, 1'b0);
        chk1("rst_err", c_err | d_err, 1'b0);
        chk32("rst_m_addr", m_addr, 32'd0);
        chk32("rst_m_wdata", m_wdata, 32'd0);
        chk32("rst_c_rdata", c_rdata, 32'd0);
        chk32("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: core first, then strict alternation
        set_c(1'b0, 32'h0000_1000, 32'd0);
        set_d(1'b0, 32'h0000_2000, 32'd0);
        for (int i = 0; i < 20; i++) begin
            do_txn(0, (i < 19), 1'b0, 32'd0);
            chk1("alternate", win_last, 1'(i % 2));
            if (i > 0) chk32("done_spacing", 32'(gap), 32'd3);
        end
        do_txn(0, 1'b0, 1'b0, 32'd0);   // drain the remaining requester

        // Single core load
        set_c(1'b0, 32'h0000_0100, 32'd0);
        do_txn(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk32("load_data", c_rdata, 32'hDEAD_BEEF);

        // Debug store with 4 wait cycles
        set_d(1'b1, 32'h0000_0020, 32'h0000_0055);
        do_txn(4, 1'b0, 1'b0, 32'd0);

        // Timeout abort, then m_ready on the final allowed cycle
        set_c(1'b0, 32'h0000_0300, 32'd0);
        do_txn(40, 1'b0, 1'b0, 32'd0);
        set_c(1'b0, 32'h0000_0304, 32'd0);
        do_txn(TO - 1, 1'b0, 1'b0, 32'h1234_5678);

        // Payload change after selection is ignored
        set_c(1'b0, 32'h0000_0100, 32'd0);
        do_txn(3, 1'b0, 1'b1, 32'd0);

        // Reset in the middle of an access
        set_c(1'b0, 32'h0000_0400, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("rst_mid_m_req", m_req, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_done", c_done, 1'b0);
        @(negedge clk);
        chk1("rst_mid_no_done", c_done, 1'b0);
        rst = 1'b0;
        last_d = 1'b1; exp_c_rdata = '0; exp_d_rdata = '0;
        set_c(1'b0, 32'h0000_0500, 32'd0);
        set_d(1'b0, 32'h0000_0600, 32'd0);
        do_txn(1, 1'b0, 1'b0, 32'd0);
        chk1("core_first_after_rst", win_last, 1'b0);
        do_txn(0, 1'b0, 1'b0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (!c_req && ($urandom_range(0, 1) == 1))
                set_c(1'($urandom), $urandom, $urandom);
            if (!d_req && ($urandom_range(0, 1) == 1))
                set_d(1'($urandom), $urandom, $urandom);
            if (!c_req && !d_req)
                set_c(1'($urandom), $urandom, $urandom);
            do_txn($urandom_range(0, 17), 1'($urandom), 1'($urandom), 32'd0);
        end
        for (int i = 0; i < 4 && (c_req || d_req); i++)
            do_txn(0, 1'b0, 1'b0, 32'd0);
        chk1("drained", c_req | d_req | busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
